exec_unit_pipe: RTL
===================

Name: exec_unit_pipe

Overview:
- Parametrised, handshaked successor to the single-cycle execution ALU in the MIPS datapath.
- Accepts one operation per transfer on a valid/ready input channel and returns a registered result, zero and overflow on a valid/ready output channel.
- Adds an iterative shift-add multiply, and holds results under back-pressure. This lets the unit sit in a pipelined core between decode/register-read and memory stages.

Parameters:
- WIDTH, 32, operand/result width in bits; power of two, at least 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept this cycle.
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt).
- imm  in  WIDTH  sign-extended immediate.
- alu_src  in  1  1 selects imm as operand B, 0 selects b.
- op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRL, 6 SRA, 7 SGT, 8 SLT, 9 MUL; 10-15 illegal.
- shamt  in  SHW  shift amount for ops 4-6.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow (ADD/SUB only).
- illegal  out  1  op was 10-15.

Behaviour:
- Reset (async assert, sync-safe deassert) forces:
  - state IDLE
  - out_valid=0, result=0, zero=0, overflow=0, illegal=0
  - multiply counter=0
- Transfer rules:
  - Input transfer happens when in_valid && in_ready at a rising edge.
  - Output transfer happens when out_valid && out_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A result may drain and a new op be accepted in the same cycle.
- Operand B = alu_src ? imm : b, sampled at acceptance.
- Single-cycle ops (0-8, 10-15):
  - Result registered at the acceptance edge; out_valid=1 from the next cycle, so latency is 1.
  - Back-to-back throughput is 1 op/cycle while out_ready=1.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - overflow=1 when operand signs match (ADD) or differ (SUB) and the result sign differs from A.
  - overflow=0 for all other ops.
- Shifts operate on A by shamt. SRA replicates A[WIDTH-1]. shamt=0 passes A unchanged.
- SGT/SLT are signed compares; result is 1 or 0 in bit 0, upper bits 0.
- Illegal op: result=0, zero=1, illegal=1, latency 1. The op still produces an output transfer.
- MUL:
  - State machine IDLE -> BUSY on acceptance of op 9.
  - Multiplicand and multiplier are latched. BUSY runs WIDTH shift-add iterations, one per cycle, with the counter counting 0..WIDTH-1.
  - On the last iteration the machine moves to IDLE and loads result with the low WIDTH bits of the signed product. Two's-complement low half equals the unsigned low half.
  - out_valid rises WIDTH+1 cycles after the acceptance edge.
  - in_ready=0 throughout BUSY.
- Hold: while out_valid && !out_ready, result/zero/overflow/illegal stay stable and no new op is accepted.
- zero is computed from the value being loaded into result, registered alongside it.
- Reset during BUSY aborts the multiply; no output is produced.
- Input fields are don't-care when in_valid=0.

Optional Feature:
- Macro EXEC_MUL_EN.
  - Defined: MUL datapath, BUSY state and counter are present, as above.
  - Undefined: no multiplier logic; op 9 is treated as illegal (result=0, illegal=1, latency 1). The state machine reduces to IDLE only.

Decomposition:
- Package exec_pkg holds:
  - the opcode enum (OP_ADD..OP_MUL)
  - the state enum (ST_IDLE, ST_BUSY)
  - the function that computes single-cycle results and overflow
- One sub-module is natural: exec_mul_iter, the shift-add multiplier with start/done, instantiated only under EXEC_MUL_EN.

Test Plan:
- WIDTH=32, a=-15, b=-22, op=ADD, out_ready=1 -> next cycle result=-37 (0xFFFFFFDB), overflow=0, zero=0; op=SUB -> result=7, overflow=0.
- a=0x7FFFFFFF, b=1, ADD -> result=0x80000000, overflow=1; a=5, alu_src=1, imm=-5, ADD -> result=0, zero=1.
- a=-15 (0xFFFFFFF1), shamt=1: SLL -> 0xFFFFFFE2; SRL -> 0x7FFFFFF8; SRA -> 0xFFFFFFF8; SGT(-15,-22) -> 1; SLT -> 0.
- MUL a=7, b=-3 -> in_ready low for 32 cycles; out_valid at acceptance+33; result=-21 (0xFFFFFFEB). Without EXEC_MUL_EN -> result=0, illegal=1 after 1 cycle.
- Back-pressure: issue ADD then OR with out_ready=0 for 5 cycles -> first result held stable, in_ready=0; release -> results delivered in order, one per cycle.
- Assert rst_n=0 at cycle 10 of a MUL -> all outputs 0 immediately; after release in_ready=1, and no stale out_valid appears.

Source files
------------

// File: rtl/exec_unit_pipe_pkg.sv
// exec_pkg: shared types and the single-cycle datapath for exec_unit_pipe.
//   op_e    - opcode encoding (OP_ADD..OP_MUL); 10-15 are illegal.
//   st_e    - control states of the unit (ST_IDLE, ST_BUSY).
//   calc_t  - result/overflow/illegal bundle from exec_calc.
//   exec_calc - computes every single-cycle op at an arbitrary width w <= XW.
//     Operands arrive zero-extended to XW bits. Only the low w bits of the result are meaningful.
package exec_pkg;

  // Widest operand width the shared datapath function supports.
  localparam int unsigned XW = 64;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_SLL = 4'd4,
    OP_SRL = 4'd5,
    OP_SRA = 4'd6,
    OP_SGT = 4'd7,
    OP_SLT = 4'd8,
    OP_MUL = 4'd9
  } op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } st_e;

  typedef struct packed {
    logic [XW-1:0] res;
    logic          ov;
    logic          ill;
  } calc_t;

  // MUL is not a single-cycle op, so it falls into the illegal branch here.
  // The top only uses this result for MUL when the multiplier is compiled out.
  function automatic calc_t exec_calc(input logic [3:0]    op,
                                      input logic [XW-1:0] a,
                                      input logic [XW-1:0] b,
                                      input int unsigned   sh,
                                      input int unsigned   w);
    logic [XW-1:0] mask;
    logic [XW-1:0] top;
    logic [XW-1:0] a_sx;
    logic [XW-1:0] b_sx;
    logic [XW-1:0] r;
    logic          sa;
    logic          sb;
    logic          sr;
    calc_t         c;

    mask = (w >= XW) ? '1 : ((XW'(1) << w) - XW'(1));
    // top isolates the sign bit of a w-bit value.
    top  = mask & ~(mask >> 1);
    sa   = |(a & top);
    sb   = |(b & top);
    a_sx = sa ? (a | ~mask) : (a & mask);
    b_sx = sb ? (b | ~mask) : (b & mask);

    r     = '0;
    c.ov  = 1'b0;
    c.ill = 1'b0;
    case (op)
      OP_ADD:  r = (a + b) & mask;
      OP_SUB:  r = (a - b) & mask;
      OP_AND:  r = a & b & mask;
      OP_OR:   r = (a | b) & mask;
      OP_SLL:  r = (a << sh) & mask;
      OP_SRL:  r = (a & mask) >> sh;
      OP_SRA:  r = ($signed(a_sx) >>> sh) & mask;
      OP_SGT:  r = {{(XW-1){1'b0}}, ($signed(a_sx) > $signed(b_sx))};
      OP_SLT:  r = {{(XW-1){1'b0}}, ($signed(a_sx) < $signed(b_sx))};
      default: c.ill = 1'b1;
    endcase

    sr = |(r & top);
    if (op == OP_ADD) c.ov = (sa == sb) && (sr != sa);
    if (op == OP_SUB) c.ov = (sa != sb) && (sr != sa);
    c.res = r;
    return c;
  endfunction

endpackage

// File: rtl/exec_unit_pipe_mul_iter.sv
// exec_mul_iter: iterative shift-add multiplier, low WIDTH bits of the product.
//   clk, rst_n   - clock, async active-low reset
//   start        - latch mcand/mplier and begin WIDTH iterations
//   mcand/mplier - operands (two's complement; the low half needs no sign fix)
//   last         - high during the final iteration; prod is valid in that cycle
//   prod         - accumulator value after the current iteration's add
module exec_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             last,
  output logic [WIDTH-1:0] prod
);

  localparam int unsigned     CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  logic             busy_q,   busy_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_next;

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last     = busy_q && (cnt_q == CNT_LAST);
  assign prod     = acc_next;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = mcand;
      mplier_d = mplier;
    end else if (busy_q) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d  = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/exec_unit_pipe.sv
// exec_unit_pipe: handshaked execution unit with registered result.
//   in_valid/in_ready   - operation channel (a, b, imm, alu_src, op, shamt)
//   out_valid/out_ready - result channel (result, zero, overflow, illegal)
// Single-cycle ops complete with latency 1. MUL takes WIDTH+1 cycles.
// Build macro EXEC_MUL_EN: when defined, MUL uses the iterative multiplier.
// When undefined, op 9 completes as an illegal op.
//
// state   | meaning
// ST_IDLE | accepting ops whenever the output register is free or draining
// ST_BUSY | multiply iterating; input closed (only with EXEC_MUL_EN)
module exec_unit_pipe
  import exec_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  input  logic             alu_src,
  input  logic [3:0]       op,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  st_e              state_q,     state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             zero_q,      zero_d;
  logic             overflow_q,  overflow_d;
  logic             illegal_q,   illegal_d;

  logic [WIDTH-1:0] opb;
  logic             accept;
  logic             acc_mul;
  calc_t            calc;
  logic             unused_calc;

  assign opb      = alu_src ? imm : b;
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb calc = exec_calc(op, XW'(a), XW'(opb), 32'(shamt), WIDTH);
  // Bits above WIDTH are always zero from exec_calc.
  assign unused_calc = ^calc.res;

`ifdef EXEC_MUL_EN
  logic             mul_start;
  logic             mul_last;
  logic [WIDTH-1:0] mul_prod;

  assign acc_mul   = (op == OP_MUL);
  assign mul_start = accept && acc_mul;

  exec_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mul_start),
    .mcand  (a),
    .mplier (opb),
    .last   (mul_last),
    .prod   (mul_prod)
  );
`else
  assign acc_mul = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    illegal_d   = illegal_q;

    if (accept && !acc_mul) begin
      out_valid_d = 1'b1;
      result_d    = calc.res[WIDTH-1:0];
      zero_d      = (calc.res[WIDTH-1:0] == '0);
      overflow_d  = calc.ov;
      illegal_d   = calc.ill;
    end

    // Output registers keep their old contents while multiplying; out_valid is
    // already low because acceptance required the output to be free.
    if (accept && acc_mul) state_d = ST_BUSY;

`ifdef EXEC_MUL_EN
    if ((state_q == ST_BUSY) && mul_last) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b1;
      result_d    = mul_prod;
      zero_d      = (mul_prod == '0);
      overflow_d  = 1'b0;
      illegal_d   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;

endmodule
